// File: rtl/descramble.sv
// Self-synchronizing descrambler for the x^11 + x^9 + 1 team scrambler with lock detection.
// Define DESCRAMBLE_TIMEOUT_EN to build the lock-loss timer; otherwise LOCKED is left only by rst.
module descramble (
   input  logic clk,
   input  logic rst,
   input  logic scrambled,
   input  logic scrambled_valid,
   output logic descrambled,
   output logic descrambled_valid,
   output logic locked
);

   localparam int LOAD_BITS = 11;
   localparam int LOCK_RUN  = 60;
   localparam int IDLE_RUN  = 29;
   localparam int LOAD_W    = $clog2(LOAD_BITS + 1);
   localparam int RUN_W     = $clog2(LOCK_RUN + 1);

   localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_BITS - 1);
   localparam logic [RUN_W-1:0]  LOCK_LAST = RUN_W'(LOCK_RUN - 1);
   localparam logic [RUN_W-1:0]  IDLE_MAX  = RUN_W'(IDLE_RUN);

`ifdef DESCRAMBLE_TIMEOUT_EN
   localparam int TIMEOUT = 90250;
   localparam int TIMER_W = $clog2(TIMEOUT + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
`endif

   typedef enum logic [1:0] {
      UNLOCKED,
      CHECK,
      LOCKED
   } state_t;

   state_t              state, state_n;
   logic [10:0]         lfsr, lfsr_n;
   logic [LOAD_W-1:0]   load_cnt, load_n;
   logic [RUN_W-1:0]    run_cnt, run_n;
   logic                valid_q;
   logic                lfsr_next;
   logic                desc_bit;

`ifdef DESCRAMBLE_TIMEOUT_EN
   logic [TIMER_W-1:0]  timer, timer_n;
`endif

   assign lfsr_next = lfsr[8] ^ lfsr[10];
   assign desc_bit  = scrambled ^ lfsr_next;

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_n = state;
      lfsr_n  = lfsr;
      load_n  = load_cnt;
      run_n   = run_cnt;
`ifdef DESCRAMBLE_TIMEOUT_EN
      timer_n = timer;
`endif
      if (scrambled_valid) begin
         case (state)
            UNLOCKED: begin
               // The remote scrambler is assumed to be sending idle ones, so ~scrambled is its LFSR output.
               lfsr_n = {lfsr[9:0], ~scrambled};
               if (load_cnt == LOAD_LAST) begin
                  state_n = CHECK;
                  load_n  = '0;
                  run_n   = '0;
               end else begin
                  load_n = load_cnt + 1'b1;
               end
            end
            CHECK: begin
               lfsr_n = {lfsr[9:0], lfsr_next};
               if (!desc_bit) begin
                  state_n = UNLOCKED;
                  load_n  = '0;
                  run_n   = '0;
               end else if (run_cnt == LOCK_LAST) begin
                  state_n = LOCKED;
                  run_n   = '0;
`ifdef DESCRAMBLE_TIMEOUT_EN
                  timer_n = '0;
`endif
               end else begin
                  run_n = run_cnt + 1'b1;
               end
            end
            LOCKED: begin
               lfsr_n = {lfsr[9:0], lfsr_next};
               if (!desc_bit)
                  run_n = '0;
               else if (run_cnt < IDLE_MAX)
                  run_n = run_cnt + 1'b1;
`ifdef DESCRAMBLE_TIMEOUT_EN
               // An idle run completing on the timeout bit keeps the lock.
               if (run_n == IDLE_MAX) begin
                  timer_n = '0;
               end else if (timer == TIMER_LAST) begin
                  state_n = UNLOCKED;
                  load_n  = '0;
                  run_n   = '0;
                  timer_n = '0;
               end else begin
                  timer_n = timer + 1'b1;
               end
`endif
            end
            default: begin
               state_n = UNLOCKED;
               load_n  = '0;
               run_n   = '0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= UNLOCKED;
         lfsr        <= 11'h7FF;
         load_cnt    <= '0;
         run_cnt     <= '0;
         descrambled <= 1'b0;
         valid_q     <= 1'b0;
`ifdef DESCRAMBLE_TIMEOUT_EN
         timer       <= '0;
`endif
      end else begin
         state    <= state_n;
         lfsr     <= lfsr_n;
         load_cnt <= load_n;
         run_cnt  <= run_n;
         valid_q  <= scrambled_valid;
`ifdef DESCRAMBLE_TIMEOUT_EN
         timer    <= timer_n;
`endif
         if (scrambled_valid)
            descrambled <= desc_bit;
      end
   end

   // Decoded from the state register so lock rises and falls on the state-change edge.
   assign locked            = (state == LOCKED);
   assign descrambled_valid = valid_q & locked;

endmodule
